// File: rtl/keypad_pkg.sv
// Shared types and helpers for the microwave keypad encoder.
// Holds the controller state encoding and the key-line to digit mapping.
package keypad_pkg;

    localparam int unsigned MAX_KEYS = 16;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        REPORT,
        HOLD
    } state_t;

    // Line i carries digit (num_keys - i) mod num_keys, so line 0 is the zero key.
    function automatic int unsigned key_code(input int unsigned index, input int unsigned num_keys);
        return (num_keys - index) % num_keys;
    endfunction

endpackage

// File: rtl/keypad_prio.sv
// Fixed-priority resolver: the highest-index asserted key line wins.
// Also flags whether any line, or more than one line, is asserted.
module keypad_prio
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 10,
    parameter int unsigned DIGIT_W  = $clog2(NUM_KEYS)
) (
    input  logic [NUM_KEYS-1:0] keys,
    output logic [DIGIT_W-1:0]  digit,
    output logic                any_key,
    output logic                multi
);

    // Ascending scan; later (higher) hits overwrite earlier ones.
    always_comb begin
        digit   = '0;
        any_key = 1'b0;
        multi   = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                multi   = multi | any_key;
                any_key = 1'b1;
                digit   = DIGIT_W'(key_code(i, NUM_KEYS));
            end
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced keypad encoder: synchronises raw key lines, accepts a stable press,
// reports one encoded digit per press over an active-low valid/ack handshake.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic [NUM_KEYS-1:0]         keypad,
    input  logic                        ackn,
    output logic [$clog2(NUM_KEYS)-1:0] digit,
    output logic                        validn,
    output logic                        multi
);

    localparam int unsigned DIGIT_W = $clog2(NUM_KEYS);
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] s;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [NUM_KEYS-1:0] candidate;
    logic [NUM_KEYS-1:0] candidate_next;
    logic [DIGIT_W-1:0]  digit_next;
    logic                multi_next;
    logic                validn_next;

    logic [NUM_KEYS-1:0] prio_vec;
    logic [DIGIT_W-1:0]  prio_digit;
    logic                prio_any;
    logic                prio_multi;

    // With single-sample acceptance IDLE reports straight from s, before the
    // candidate register holds it; otherwise s equals candidate at acceptance.
    assign prio_vec = (DEBOUNCE_CYCLES == 1) ? s : candidate;

    keypad_prio #(
        .NUM_KEYS (NUM_KEYS),
        .DIGIT_W  (DIGIT_W)
    ) u_prio (
        .keys    (prio_vec),
        .digit   (prio_digit),
        .any_key (prio_any),
        .multi   (prio_multi)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_meta <= '0;
            s         <= '0;
            state     <= IDLE;
            cnt       <= '0;
            candidate <= '0;
            digit     <= '0;
            multi     <= 1'b0;
            validn    <= 1'b1;
        end else begin
            sync_meta <= keypad;
            s         <= sync_meta;
            state     <= state_next;
            cnt       <= cnt_next;
            candidate <= candidate_next;
            digit     <= digit_next;
            multi     <= multi_next;
            validn    <= validn_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        candidate_next = candidate;
        digit_next     = digit;
        multi_next     = multi;
        validn_next    = validn;

        if (!enable) begin
            state_next     = IDLE;
            cnt_next       = '0;
            candidate_next = '0;
            validn_next    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    validn_next = 1'b1;
                    if (s != '0) begin
                        candidate_next = s;
                        cnt_next       = CNT_ONE;
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_next  = REPORT;
                            digit_next  = prio_digit;
                            multi_next  = prio_multi;
                            validn_next = 1'b0;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (s == '0) begin
                        state_next     = IDLE;
                        cnt_next       = '0;
                        candidate_next = '0;
                    end else if (s != candidate) begin
                        candidate_next = s;
                        cnt_next       = CNT_ONE;
                    end else if (prio_any && cnt == CNT_LAST) begin
                        state_next  = REPORT;
                        cnt_next    = '0;
                        digit_next  = prio_digit;
                        multi_next  = prio_multi;
                        validn_next = 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end

                REPORT: begin
                    validn_next = 1'b0;
                    if (!ackn) begin
                        validn_next = 1'b1;
                        state_next  = HOLD;
                        cnt_next    = '0;
                    end
                end

                HOLD: begin
                    // Release must be seen as an unbroken run of zero samples.
                    if (s != '0) begin
                        cnt_next = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next     = IDLE;
                        cnt_next       = '0;
                        candidate_next = '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end

                default: begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    candidate_next = '0;
                    validn_next    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder (10 keys, 4-sample debounce).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_encoder;

    localparam int unsigned NUM_KEYS        = 10;
    localparam int unsigned DEBOUNCE_CYCLES = 4;

    logic                clock;
    logic                resetn;
    logic                enable;
    logic [NUM_KEYS-1:0] keypad;
    logic                ackn;
    logic [3:0]          digit;
    logic                validn;
    logic                multi;

    int checks;
    int errors;

    keypad_encoder #(
        .NUM_KEYS        (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .enable (enable),
        .keypad (keypad),
        .ackn   (ackn),
        .digit  (digit),
        .validn (validn),
        .multi  (multi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Edges until validn is seen low (the first edge after the call is 1); -1 on timeout.
    task automatic wait_valid(output int edges);
        edges = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (!validn) begin
                edges = n;
                break;
            end
        end
    endtask

    // Count cycles with validn low over a window.
    task automatic watch(input int cycles, output int lows);
        lows = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            if (!validn) lows++;
        end
    endtask

    task automatic press(input string tag, input logic [NUM_KEYS-1:0] k,
                         input int exp_digit, input int exp_multi);
        int e;
        keypad = k;
        wait_valid(e);
        check({tag, "_latency"}, e, 6);
        check({tag, "_digit"}, int'(digit), exp_digit);
        check({tag, "_multi"}, int'(multi), exp_multi);
    endtask

    task automatic do_ack(input string tag);
        ackn = 1'b0;
        @(negedge clock);
        check({tag, "_validn"}, int'(validn), 1);
        ackn = 1'b1;
    endtask

    // Two synchroniser stages plus four zero samples return HOLD to IDLE.
    task automatic release_key();
        keypad = '0;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        int e;
        int lows;
        int total;

        checks = 0;
        errors = 0;
        resetn = 1'b0;
        enable = 1'b1;
        ackn   = 1'b1;
        keypad = 10'b1000000000;

        // Reset held for three edges with a key down.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_validn", int'(validn), 1);
            check("rst_digit", int'(digit), 0);
            check("rst_multi", int'(multi), 0);
        end
        resetn = 1'b1;
        wait_valid(e);
        check("rst_release_latency", e, 6);
        check("rst_release_digit", int'(digit), 1);
        do_ack("rst_ack");
        release_key();

        // Clean press, single-cycle ack, then a long hold yields nothing more.
        press("clean", 10'b0000000010, 9, 0);
        do_ack("clean_ack");
        watch(20, lows);
        check("clean_no_repeat", lows, 0);
        release_key();

        // Bouncing contact: 2-cycle pulses never survive debounce.
        total = 0;
        for (int i = 0; i < 6; i++) begin
            keypad = (i % 2 == 0) ? 10'b0000100000 : 10'b0000000000;
            watch(2, lows);
            total += lows;
        end
        check("bounce_no_event", total, 0);
        press("bounce", 10'b0000100000, 5, 0);
        do_ack("bounce_ack");
        watch(10, lows);
        check("bounce_single_event", lows, 0);
        release_key();

        // Two keys: line 8 beats line 2.
        press("multi", 10'b0100000100, 2, 1);
        do_ack("multi_ack");
        release_key();

        // Zero key with ackn already low: event still shows for one cycle.
        ackn = 1'b0;
        press("zero", 10'b0000000001, 0, 0);
        @(negedge clock);
        check("zero_pulse_width", int'(validn), 1);
        ackn = 1'b1;
        release_key();

        // Release glitch: 3 zeros, 1-cycle key, 3 zeros, then a new key held.
        press("glitch_pre", 10'b0000000100, 8, 0);
        do_ack("glitch_pre_ack");
        total = 0;
        keypad = '0;
        watch(3, lows);
        total += lows;
        keypad = 10'b0000001000;
        watch(1, lows);
        total += lows;
        keypad = '0;
        watch(3, lows);
        total += lows;
        keypad = 10'b0000010000;
        watch(20, lows);
        total += lows;
        check("glitch_no_event", total, 0);

        // Exactly four zero cycles is enough to rearm.
        keypad = '0;
        watch(4, lows);
        check("rearm_gap_quiet", lows, 0);
        press("rearm", 10'b0000010000, 6, 0);
        do_ack("rearm_ack");
        release_key();

        // Enable drop in REPORT: drop edge is edge 1, enable back after edge 2.
        press("en_pre", 10'b0000000010, 9, 0);
        enable = 1'b0;
        @(negedge clock);
        check("en_drop_validn", int'(validn), 1);
        check("en_drop_digit_hold", int'(digit), 9);
        @(negedge clock);
        check("en_off_validn", int'(validn), 1);
        enable = 1'b1;
        wait_valid(e);
        check("en_fresh_edge", (e < 0) ? -1 : e + 2, 6);
        check("en_fresh_digit", int'(digit), 9);
        do_ack("en_ack");
        release_key();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Parametrised, debounced keypad encoder for the microwave front panel. It samples a raw one-hot-per-key vector, synchronises and debounces it, and resolves simultaneous keys by fixed priority. It emits exactly one encoded digit event per physical press over a valid/acknowledge handshake. It sits between the panel key lines and the time-entry logic.

## Interface

- NUM_KEYS, 10: number of key lines; legal range 2..16.
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to accept a press or a release; legal values ≥1.
- DIGIT_W, $clog2(NUM_KEYS): width of the digit code; derived, do not override.

- clock  in  1  single rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  1 = block active; 0 = forced idle and any pending event discarded.
- keypad  in  NUM_KEYS  raw key lines, asynchronous, 1 = pressed.
- ackn  in  1  active-low acknowledge from the consumer; sampled only in REPORT.
- digit  out  DIGIT_W  encoded key code; valid while validn=0.
- validn  out  1  active-low event valid.
- multi  out  1  1 = more than one key was asserted in the accepted vector; valid with digit.

## Operation

- Two-flop synchroniser on keypad, reset to 0. All decisions use its output `s`.
- Key code: bit i maps to digit (NUM_KEYS − i) mod NUM_KEYS. With 10 keys, bit9 maps to 1, bit1 to 9, and bit0 to 0.
- Priority: the highest-index asserted bit wins. multi = popcount(vector) > 1.
- States:
  - IDLE: if s≠0, capture candidate=s and set cnt=1. Go to DEBOUNCE, or go directly to REPORT if DEBOUNCE_CYCLES=1.
  - DEBOUNCE:
    - If s=0, go to IDLE.
    - If s≠candidate and s≠0, recapture candidate=s and set cnt=1.
    - If s=candidate and cnt=DEBOUNCE_CYCLES−1, register digit and multi from the candidate, drive validn=0, and go to REPORT.
    - Otherwise increment cnt.
  - REPORT: hold digit, multi and validn=0. When ackn=0, set validn=1 at the next edge and go to HOLD. Key changes are ignored in this state.
  - HOLD: count consecutive cycles with s=0. Any s≠0 restarts the count at 0. When the count reaches DEBOUNCE_CYCLES, go to IDLE. A key held indefinitely never produces a second event.
- The counter width is $clog2(DEBOUNCE_CYCLES+1) and it saturates, so it never wraps.
- When enable=0, the next edge forces IDLE, validn=1, cnt=0 and candidate=0. The synchroniser keeps running and digit/multi hold their last values.
- Reset values: digit=0, validn=1, multi=0, state IDLE, cnt=0, synchroniser=0.

## Timing

- All outputs are registered, with no combinational input-to-output path.
- Press latency: count the first rising edge at which a stable raw vector is present as edge 1. validn falls on edge DEBOUNCE_CYCLES+2, which is edge 6 at the default setting.
- Acknowledge: ackn=0 sampled on an edge where validn is already 0 raises validn on that same edge. An event lasts at least 1 cycle.
- ackn=0 held continuously before REPORT is entered does not suppress the event. The event still shows validn=0 for exactly 1 cycle.
- Minimum spacing between two events: 1 (REPORT) + DEBOUNCE_CYCLES (HOLD release) + DEBOUNCE_CYCLES+1 (next press) cycles.
- resetn=0 or enable=0 in any state takes priority over every other transition on that edge.

## Structure

- Package keypad_pkg holds:
  - the state enum (IDLE, DEBOUNCE, REPORT, HOLD);
  - the function key_code(index, NUM_KEYS) implementing the mod mapping.
- One sub-module, keypad_prio: purely combinational, taking the NUM_KEYS vector and producing the winning digit, an any-key flag and multi. The top-level state machine instantiates it once on the candidate register.

## Test plan

All scenarios use NUM_KEYS=10 and DEBOUNCE_CYCLES=4.

- Reset: hold resetn=0 for 3 cycles with keypad=10'b1000000000. Required: validn=1, digit=0, multi=0 throughout. After release, validn=0 at edge 6 with digit=1.
- Clean press: hold keypad=10'b0000000010. Required: validn=0 at edge 6, digit=9, multi=0. Then pulse ackn=0 for 1 cycle. Required: validn=1 next edge and no further event while the key stays held.
- Bounce: toggle keypad between 10'b0000100000 and 0 every 2 cycles for 12 cycles, then hold. Required: exactly one event, digit=5, with validn falling 6 edges after the final stable onset.
- Multi-key and zero key: apply 10'b0100000100. Required: digit=2, multi=1. Then release, wait 4+ cycles, and apply 10'b0000000001. Required: digit=0, multi=0, validn=0.
- Release glitch: during HOLD, drive keypad 0 for 3 cycles, then 1 cycle of 10'b0000001000, then 0. Required: no new event, and IDLE entered only after 4 consecutive zero samples.
- Enable drop: set enable=0 in REPORT. Required: validn=1 next edge and the event is lost. Then re-enable with the key still held. Required: a fresh event 6 edges later.
